pipeline_sched: RTL
===================

PIPELINE_SCHED -- requirements
Module: pipeline_sched

Interface
REQ-001 Parameter DATA_W, default 32, width of request, pipeline and response data.
REQ-002 Parameter DRAIN_CYC, default 3, cycles the block holds off issue after a flush.
REQ-003 clk  in  1  single clock; all state updates on rising edge.
REQ-004 reset_n  in  1  reset, asynchronous and active-low.
REQ-005 req0_valid  in  1  requester 0 offers a word.
REQ-006 req0_data  in  DATA_W  requester 0 word.
REQ-007 req0_ready  out  1  requester 0 word accepted this cycle.
REQ-008 req1_valid, req1_data, req1_ready  in/in/out  1/DATA_W/1  same as REQ-005..007 for requester 1.
REQ-009 flush_req  in  1  one-cycle flush request, any source.
REQ-010 out_ready  in  1  downstream consumer can accept a response.
REQ-011 pipe_inputs  out  DATA_W  word driven into the 3-stage pipeline.
REQ-012 pipe_in_valid  out  1  pipe_inputs is valid.
REQ-013 pipe_flush  out  1  flush to pipeline stage 1.
REQ-014 pipe_stall  out  1  global pipeline stall.
REQ-015 pipe_outputs  in  DATA_W  pipeline stage-3 data.
REQ-016 pipe_out_valid  in  1  pipeline stage-3 valid.
REQ-017 resp_data  out  DATA_W  pipe_outputs passed through combinationally.
REQ-018 resp_valid  out  1  response valid, tagged by resp_id.
REQ-019 resp_id  out  1  requester (0/1) that issued the response.
REQ-020 inflight  out  2  count of valid words in the pipeline, 0..3.

Function
REQ-021 FSM states: RUN, DRAIN. The block shall leave reset in RUN.
REQ-022 pipe_stall shall equal ~out_ready combinationally in both states.
REQ-023 Issue is allowed only in RUN, with pipe_stall=0 and flush_req=0.
REQ-024 Arbitration: round-robin with 1-bit priority pointer rr; if both valid, grant req[rr]; if one valid, grant that one.
REQ-025 After a grant, rr shall become the complement of the granted id; rr is unchanged when there is no grant.
REQ-026 On grant: reqN_ready=1 for the granted requester only, pipe_inputs=reqN_data, pipe_in_valid=1, all in the same cycle (combinational).
REQ-027 With no grant: pipe_in_valid=0, pipe_inputs=0, both readys=0.
REQ-028 Tag shift register tag[1:3] (id, valid) tracks pipeline stages. When pipe_stall=0 it shifts each cycle, with tag[1] loaded from the grant (valid=1, id) or invalid. When pipe_stall=1 it holds.
REQ-029 resp_valid=pipe_out_valid AND tag[3].valid AND state==RUN; resp_id=tag[3].id.
REQ-030 inflight shall equal the number of valid tags, updated with the tag register.
REQ-031 A pipe_out_valid=1 with tag[3] invalid is a protocol error: resp_valid stays 0 and the sticky internal flag err is set (exposed for assertions only).
REQ-032 flush_req in RUN: pipe_flush=1 that cycle; no grant; all tags invalid next cycle; inflight=0 next cycle; state→DRAIN with counter=DRAIN_CYC-1.
REQ-033 DRAIN: no grant, resp_valid=0, pipe_flush=0; counter decrements each cycle regardless of stall; at 0 → RUN.
REQ-034 flush_req in DRAIN shall reload counter to DRAIN_CYC-1 and pulse pipe_flush again.
REQ-035 flush_req and a valid request in the same cycle: flush wins; no readys asserted; rr unchanged.

Reset
REQ-036 While reset_n=0: state=RUN, rr=0, tags invalid, counter=0, err=0.
REQ-037 While reset_n=0: all ready/valid/flush outputs=0, pipe_inputs=0, inflight=0, and pipe_stall=~out_ready.
REQ-038 Reset asserted mid-operation shall discard all in-flight tags immediately (asynchronous).

Verification
REQ-039 Both requesters valid for 4 cycles, out_ready=1 → grants 0,1,0,1; responses on cycles 3..6 with resp_id 0,1,0,1 and matching data.
REQ-040 Only req1 valid with data 0xA5A5A5A5 → req1_ready same cycle; resp_valid, resp_id=1, resp_data=0xA5A5A5A5 three cycles later.
REQ-041 Issue 2 words, then out_ready=0 for 5 cycles → pipe_stall=1, no grants, inflight holds at 2, no response until out_ready returns.
REQ-042 flush_req with 3 words in flight → pipe_flush pulse, inflight=0 next cycle, no grants/responses for 3 cycles, then issue resumes.
REQ-043 flush_req with req0_valid in the same cycle, then a second flush_req 1 cycle later → req0_ready=0; DRAIN extended to 3 cycles after the second flush.
REQ-044 reset_n low mid-stream with inflight=2 → outputs reach reset values without a clock edge; after release, first grant goes to req0.

Source files
------------

// File: rtl/pipeline_sched_if.sv
`default_nettype none
// ============================================================================
// Module      : pipeline_sched_if
// Description : Bundles the requester handshakes, the pipeline drive/return
//               signals and the tagged response path of pipeline_sched.
//               Ports (by group):
//                 requesters : req0/req1 valid, data, ready
//                 control    : flush_req, out_ready
//                 pipeline   : pipe_inputs, pipe_in_valid, pipe_flush,
//                              pipe_stall, pipe_outputs, pipe_out_valid
//                 response   : resp_data, resp_valid, resp_id, inflight
//                 monitor    : err (sticky protocol-error flag)
//               Modport slave is the scheduler; master is its environment.
// Revision    : 1.0 - initial release
// ============================================================================
interface pipeline_sched_if #(
  parameter int DATA_W = 32
);
  logic              req0_valid;
  logic [DATA_W-1:0] req0_data;
  logic              req0_ready;
  logic              req1_valid;
  logic [DATA_W-1:0] req1_data;
  logic              req1_ready;
  logic              flush_req;
  logic              out_ready;
  logic [DATA_W-1:0] pipe_inputs;
  logic              pipe_in_valid;
  logic              pipe_flush;
  logic              pipe_stall;
  logic [DATA_W-1:0] pipe_outputs;
  logic              pipe_out_valid;
  logic [DATA_W-1:0] resp_data;
  logic              resp_valid;
  logic              resp_id;
  logic [1:0]        inflight;
  logic              err;

  modport slave (
    input  req0_valid, req0_data, req1_valid, req1_data,
    input  flush_req, out_ready, pipe_outputs, pipe_out_valid,
    output req0_ready, req1_ready,
    output pipe_inputs, pipe_in_valid, pipe_flush, pipe_stall,
    output resp_data, resp_valid, resp_id, inflight, err
  );

  modport master (
    output req0_valid, req0_data, req1_valid, req1_data,
    output flush_req, out_ready, pipe_outputs, pipe_out_valid,
    input  req0_ready, req1_ready,
    input  pipe_inputs, pipe_in_valid, pipe_flush, pipe_stall,
    input  resp_data, resp_valid, resp_id, inflight, err
  );
endinterface
`default_nettype wire

// File: rtl/pipeline_sched.sv
`default_nettype none
// ============================================================================
// Module      : pipeline_sched
// Description : Issue scheduler for an external 3-stage pipeline. Two
//               requesters are arbitrated round-robin, the granted word is
//               driven into the pipeline, and a 3-entry tag shift register
//               follows each word so the stage-3 result can be returned
//               tagged with its requester id. A flush kills all tags and
//               holds off issue for DRAIN_CYC cycles.
//               Ports:
//                 clk     : clock, rising-edge active
//                 reset_n : asynchronous active-low reset
//                 bus     : pipeline_sched_if.slave (all handshake/data)
// Revision    : 1.0 - initial release
// ============================================================================
module pipeline_sched #(
  parameter int DATA_W    = 32,
  parameter int DRAIN_CYC = 3
) (
  input  logic                  clk,
  input  logic                  reset_n,
  pipeline_sched_if.slave       bus
);

  // Counter only ever holds DRAIN_CYC-1 down to 0.
  localparam int c_CNT_W = (DRAIN_CYC > 1) ? $clog2(DRAIN_CYC) : 1;
  localparam logic [c_CNT_W-1:0] c_DRAIN_LOAD = c_CNT_W'(DRAIN_CYC - 1);

  localparam logic [0:0] c_ST_RUN   = 1'b0;
  localparam logic [0:0] c_ST_DRAIN = 1'b1;

  // --------------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------------
  logic [0:0]         r_state;
  logic               r_rr;          // round-robin priority pointer
  logic [2:0]         r_tag_vld;     // bit 0 = stage 1 ... bit 2 = stage 3
  logic [2:0]         r_tag_id;
  logic [c_CNT_W-1:0] r_cnt;
  logic               r_err;

  // --------------------------------------------------------------------------
  // Combinational control
  // --------------------------------------------------------------------------
  logic              w_run;
  logic              w_stall;
  logic              w_issue_ok;
  logic              w_grant_vld;
  logic              w_grant_id;
  logic [DATA_W-1:0] w_issue_data;

  assign w_run   = (r_state == c_ST_RUN);
  assign w_stall = ~bus.out_ready;

  // reset_n gates the combinational outputs so they sit at their reset
  // values for the whole reset period, not just after the next edge.
  assign w_issue_ok = reset_n & w_run & ~w_stall & ~bus.flush_req;

  assign w_grant_vld = w_issue_ok & (bus.req0_valid | bus.req1_valid);
  // Both valid: pointer decides. One valid: req1_valid alone picks id 1,
  // otherwise it must be req0.
  assign w_grant_id  = (bus.req0_valid & bus.req1_valid) ? r_rr : bus.req1_valid;

  always_comb begin
    w_issue_data = '0;
    if (w_grant_vld) begin
      w_issue_data = w_grant_id ? bus.req1_data : bus.req0_data;
    end
  end

  assign bus.req0_ready    = w_grant_vld & ~w_grant_id;
  assign bus.req1_ready    = w_grant_vld &  w_grant_id;
  assign bus.pipe_inputs   = w_issue_data;
  assign bus.pipe_in_valid = w_grant_vld;
  assign bus.pipe_flush    = reset_n & bus.flush_req;
  assign bus.pipe_stall    = w_stall;

  // Responses are suppressed while draining: anything still leaving the
  // pipeline then belongs to a flushed issue.
  assign bus.resp_data  = bus.pipe_outputs;
  assign bus.resp_valid = bus.pipe_out_valid & r_tag_vld[2] & w_run;
  assign bus.resp_id    = r_tag_id[2];

  assign bus.inflight = {1'b0, r_tag_vld[0]} + {1'b0, r_tag_vld[1]}
                      + {1'b0, r_tag_vld[2]};
  assign bus.err      = r_err;

  // --------------------------------------------------------------------------
  // Arbitration pointer
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_rr <= 1'b0;
    end else if (w_grant_vld) begin
      r_rr <= ~w_grant_id;
    end
  end

  // --------------------------------------------------------------------------
  // Tag shift register: mirrors the pipeline, freezing with it on stall.
  // A flush empties it regardless of stall.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_tag_vld <= '0;
      r_tag_id  <= '0;
    end else if (bus.flush_req) begin
      r_tag_vld <= '0;
      r_tag_id  <= '0;
    end else if (!w_stall) begin
      r_tag_vld <= {r_tag_vld[1:0], w_grant_vld};
      r_tag_id  <= {r_tag_id[1:0], w_grant_vld & w_grant_id};
    end
  end

  // --------------------------------------------------------------------------
  // Sticky protocol-error flag: pipeline produced a word nobody issued.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_err <= 1'b0;
    end else if (bus.pipe_out_valid && !r_tag_vld[2]) begin
      r_err <= 1'b1;
    end
  end

  // --------------------------------------------------------------------------
  // RUN / DRAIN state machine. The drain counter ignores stall so the
  // hold-off is a fixed number of cycles after the last flush.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= c_ST_RUN;
      r_cnt   <= '0;
    end else begin
      case (r_state)
        c_ST_RUN: begin
          if (bus.flush_req) begin
            r_state <= c_ST_DRAIN;
            r_cnt   <= c_DRAIN_LOAD;
          end
        end
        c_ST_DRAIN: begin
          if (bus.flush_req) begin
            r_cnt <= c_DRAIN_LOAD;
          end else if (r_cnt == '0) begin
            r_state <= c_ST_RUN;
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        default: begin
          r_state <= c_ST_RUN;
          r_cnt   <= '0;
        end
      endcase
    end
  end

endmodule
`default_nettype wire
